// File: rtl/pyramid_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : pyramid_reader_if
// Purpose  : Bundles the pyramid reader's request, BRAM read and pixel stream
//            signals into one interface.
//   master : the pyramid reader (issues BRAM reads, drives the pixel stream)
//   slave  : the surrounding system (requester, BRAMs and stream consumer)
// Signals  :
//   start_in / octave_in / scale_in          image request
//   rd_en_out / rd_sel_out / rd_addr_out     BRAM read command
//   rd_data_in                               BRAM read data (2-cycle latency)
//   pixel_out / x_out / y_out / last_out     streamed pixel and its tags
//   valid_out / ready_in                     stream handshake
//   busy_out / done_out / error_out          status
// Revision : 1.0 - initial release
// ============================================================================
interface pyramid_reader_if #(
  parameter int BIT_DEPTH  = 8,
  parameter int ADDR_WIDTH = 15
);
  logic                  start_in;
  logic [1:0]            octave_in;
  logic [2:0]            scale_in;
  logic                  rd_en_out;
  logic [1:0]            rd_sel_out;
  logic [ADDR_WIDTH-1:0] rd_addr_out;
  logic [BIT_DEPTH-1:0]  rd_data_in;
  logic [BIT_DEPTH-1:0]  pixel_out;
  logic [7:0]            x_out;
  logic [7:0]            y_out;
  logic                  valid_out;
  logic                  ready_in;
  logic                  last_out;
  logic                  busy_out;
  logic                  done_out;
  logic                  error_out;

  modport master (
    input  start_in, octave_in, scale_in, rd_data_in, ready_in,
    output rd_en_out, rd_sel_out, rd_addr_out,
    output pixel_out, x_out, y_out, valid_out, last_out,
    output busy_out, done_out, error_out
  );

  modport slave (
    output start_in, octave_in, scale_in, rd_data_in, ready_in,
    input  rd_en_out, rd_sel_out, rd_addr_out,
    input  pixel_out, x_out, y_out, valid_out, last_out,
    input  busy_out, done_out, error_out
  );
endinterface
`default_nettype wire

// File: rtl/pyramid_reader.sv
`default_nettype none
// ============================================================================
// Module   : pyramid_reader
// Purpose  : Reads one stored image (octave, scale) out of the per-octave
//            Gaussian pyramid BRAMs in raster order and streams it with x/y
//            coordinates over a valid/ready interface.
// Ports    :
//   clk_in   system clock
//   rst_in   asynchronous active-high reset
//   bus      pyramid_reader_if.master (request, BRAM read, pixel stream,
//            busy/done/error status)
// Timing   : with ready held high the first valid pixel appears 3 cycles
//            after the accepted start edge, then one pixel per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module pyramid_reader #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int BIT_DEPTH  = 8,
  parameter int OCTAVES    = 4,
  parameter int SCALES     = 5,
  parameter int ADDR_WIDTH = $clog2(WIDTH * HEIGHT * SCALES)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  pyramid_reader_if.master bus
);

  localparam int LOG_W      = $clog2(WIDTH);
  localparam int LOG_H      = $clog2(HEIGHT);
  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]            r_state;
  logic [1:0]            w_next_state;

  logic [1:0]            r_octave;
  logic [2:0]            r_scale;
  logic [7:0]            r_rx;
  logic [7:0]            r_ry;

  // Reads issued whose data has not yet been pushed into the FIFO
  logic [2:0]            r_outst;

  // Tag delay pipe matching the 2-cycle BRAM latency
  logic                  r_p1_v;
  logic [7:0]            r_p1_x;
  logic [7:0]            r_p1_y;
  logic                  r_p1_last;
  logic                  r_p2_v;
  logic [7:0]            r_p2_x;
  logic [7:0]            r_p2_y;
  logic                  r_p2_last;

  // Output FIFO
  logic [BIT_DEPTH-1:0]  r_fifo_pix [FIFO_DEPTH];
  logic [7:0]            r_fifo_x   [FIFO_DEPTH];
  logic [7:0]            r_fifo_y   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [2:0]            r_count;

  logic                  r_done;
  logic                  r_error;

  logic                  w_start_ok;
  logic                  w_accept;
  logic [8:0]            w_wo_m1;
  logic [8:0]            w_ho_m1;
  logic                  w_rx_end;
  logic                  w_ry_end;
  logic                  w_last_coord;
  logic [4:0]            w_sh_w;
  logic [5:0]            w_sh_img;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_busy;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_pop;

  // --------------------------------------------------------------------------
  // Start validation and geometry of the selected octave
  // --------------------------------------------------------------------------
  // Zero-extended to 32 bits so the range checks stay generic in OCTAVES and
  // SCALES even when a select field can never reach the limit.
  assign w_start_ok = ({30'd0, bus.octave_in} < 32'(OCTAVES)) &&
                      ({29'd0, bus.scale_in}  < 32'(SCALES));
  assign w_accept   = (r_state == S_IDLE) && bus.start_in && w_start_ok;

  assign w_wo_m1      = (9'(WIDTH)  >> r_octave) - 9'd1;
  assign w_ho_m1      = (9'(HEIGHT) >> r_octave) - 9'd1;
  assign w_rx_end     = ({1'b0, r_rx} == w_wo_m1);
  assign w_ry_end     = ({1'b0, r_ry} == w_ho_m1);
  assign w_last_coord = w_rx_end && w_ry_end;

  // addr = scale*W_o*H_o + ry*W_o + rx using only shifts:
  // log2(W_o) = LOG_W - octave, log2(W_o*H_o) = LOG_W + LOG_H - 2*octave.
  assign w_sh_w   = 5'(LOG_W) - {3'b000, r_octave};
  assign w_sh_img = 6'(LOG_W + LOG_H) - {3'b000, r_octave, 1'b0};
  assign w_addr   = (ADDR_WIDTH'(r_scale) << w_sh_img) +
                    (ADDR_WIDTH'(r_ry)    << w_sh_w)   +
                    ADDR_WIDTH'(r_rx);

  // A read may only be issued while everything in flight plus everything
  // queued leaves a free FIFO slot for it, so returning data always fits.
  assign w_credit = ({1'b0, r_outst} + {1'b0, r_count}) < 4'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)                w_next_state = S_READ;
      S_READ:  if (w_issue && w_last_coord) w_next_state = S_DRAIN;
      S_DRAIN: if (w_last_pop)              w_next_state = S_IDLE;
      default:                              w_next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_issue = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      S_READ: begin
        w_issue = w_credit;
        w_busy  = 1'b1;
      end
      S_DRAIN: begin
        w_busy  = 1'b1;
      end
      default: begin
        w_issue = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch and raster counters (x fastest)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_octave <= 2'd0;
      r_scale  <= 3'd0;
      r_rx     <= 8'd0;
      r_ry     <= 8'd0;
    end else if (w_accept) begin
      r_octave <= bus.octave_in;
      r_scale  <= bus.scale_in;
      r_rx     <= 8'd0;
      r_ry     <= 8'd0;
    end else if (w_issue) begin
      if (w_rx_end) begin
        r_rx <= 8'd0;
        r_ry <= r_ry + 8'd1;
      end else begin
        r_rx <= r_rx + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outstanding-read counter and tag delay pipe
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_outst   <= 3'd0;
      r_p1_v    <= 1'b0;
      r_p1_x    <= 8'd0;
      r_p1_y    <= 8'd0;
      r_p1_last <= 1'b0;
      r_p2_v    <= 1'b0;
      r_p2_x    <= 8'd0;
      r_p2_y    <= 8'd0;
      r_p2_last <= 1'b0;
    end else begin
      // Issue and return in the same cycle cancel out.
      case ({w_issue, r_p2_v})
        2'b10:   r_outst <= r_outst + 3'd1;
        2'b01:   r_outst <= r_outst - 3'd1;
        default: r_outst <= r_outst;
      endcase
      r_p1_v    <= w_issue;
      r_p1_x    <= r_rx;
      r_p1_y    <= r_ry;
      r_p1_last <= w_last_coord;
      r_p2_v    <= r_p1_v;
      r_p2_x    <= r_p1_x;
      r_p2_y    <= r_p1_y;
      r_p2_last <= r_p1_last;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO: the head entry drives the stream directly from registers,
  // so a stalled pixel holds stable until it is popped.
  // --------------------------------------------------------------------------
  assign w_push     = r_p2_v;
  assign w_pop      = (r_count != 3'd0) && bus.ready_in;
  assign w_last_pop = w_pop && r_fifo_last[r_rd_ptr];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pix[i] <= '0;
        r_fifo_x[i]   <= 8'd0;
        r_fifo_y[i]   <= 8'd0;
      end
      r_fifo_last <= '0;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 3'd0;
    end else begin
      if (w_push) begin
        r_fifo_pix[r_wr_ptr]  <= bus.rd_data_in;
        r_fifo_x[r_wr_ptr]    <= r_p2_x;
        r_fifo_y[r_wr_ptr]    <= r_p2_y;
        r_fifo_last[r_wr_ptr] <= r_p2_last;
        r_wr_ptr              <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done  <= w_last_pop;
      // Only a start seen in IDLE can be rejected; starts while busy are
      // silently ignored.
      r_error <= (r_state == S_IDLE) && bus.start_in && !w_start_ok;
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.rd_en_out   = w_issue;
  assign bus.rd_sel_out  = r_octave;
  assign bus.rd_addr_out = w_addr;
  assign bus.pixel_out   = r_fifo_pix[r_rd_ptr];
  assign bus.x_out       = r_fifo_x[r_rd_ptr];
  assign bus.y_out       = r_fifo_y[r_rd_ptr];
  assign bus.last_out    = r_fifo_last[r_rd_ptr];
  assign bus.valid_out   = (r_count != 3'd0);
  assign bus.busy_out    = w_busy;
  assign bus.done_out    = r_done;
  assign bus.error_out   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_pyramid_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pyramid_reader
// Purpose  : Self-checking bench for pyramid_reader. A BRAM model returns
//            addr[7:0] ^ {sel,6'b0} two cycles after each read; expected
//            pixels are queued when an image is requested and compared on
//            every stream handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pyramid_reader;

  localparam int WIDTH  = 64;
  localparam int HEIGHT = 64;
  localparam int AW     = $clog2(WIDTH * HEIGHT * 5);

  typedef struct packed {
    logic [7:0] pix;
    logic [7:0] x;
    logic [7:0] y;
    logic       last;
  } px_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  px_t  sb[$];

  pyramid_reader_if #(.BIT_DEPTH(8), .ADDR_WIDTH(AW)) bus ();

  pyramid_reader #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BIT_DEPTH(8),
    .OCTAVES(4), .SCALES(5), .ADDR_WIDTH(AW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // BRAM model: 2-cycle read latency; garbage on non-read cycles.
  logic          m1_en;
  logic [AW-1:0] m1_addr;
  logic [1:0]    m1_sel;
  always @(posedge clk) begin
    m1_en   <= bus.rd_en_out;
    m1_addr <= bus.rd_addr_out;
    m1_sel  <= bus.rd_sel_out;
    bus.rd_data_in <= (m1_en === 1'b1) ? (m1_addr[7:0] ^ {m1_sel, 6'd0}) : 8'($urandom);
  end

  // mode 0: ready always high, 1: random ready, 2: ready low for 20 cycles
  task automatic run_image(input int oct, input int sc, input int mode,
                           input int abort_after, input bit mid_start);
    int  wo, ho, npix, base, budget, cyc, got, issued, first_lat, stall_reads;
    bit  held, err_seen;
    px_t hold_v, obs, exp_v;
    wo = WIDTH >> oct; ho = HEIGHT >> oct; npix = wo * ho; base = sc * wo * ho;
    budget = npix * 8 + 200;
    for (int k = 0; k < npix; k++) begin
      px_t e;
      int  a;
      a = base + k;
      e.pix  = 8'(a) ^ 8'(oct << 6);
      e.x    = 8'(k % wo);
      e.y    = 8'(k / wo);
      e.last = (k == npix - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start_in = 1'b1; bus.octave_in = 2'(oct); bus.scale_in = 3'(sc);
    bus.ready_in = (mode == 0);
    cyc = 0; got = 0; issued = 0; first_lat = -1; stall_reads = 0;
    held = 1'b0; err_seen = 1'b0; hold_v = '0;
    while (got < npix && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus.start_in = 1'b0;
      if (mid_start && cyc == 100) begin
        bus.start_in = 1'b1; bus.octave_in = 2'd3; bus.scale_in = 3'd5;
      end
      if (mid_start && cyc == 200) begin
        bus.start_in = 1'b1; bus.octave_in = 2'd0; bus.scale_in = 3'd0;
      end
      case (mode)
        1:       bus.ready_in = 1'($urandom_range(0, 1));
        2:       bus.ready_in = (cyc > 20);
        default: bus.ready_in = 1'b1;
      endcase
      if (bus.error_out === 1'b1) err_seen = 1'b1;
      if (bus.rd_en_out === 1'b1) begin
        checks++;
        if (bus.rd_addr_out !== AW'(base + issued) || bus.rd_sel_out !== 2'(oct)) begin
          failures++;
          $display("FAIL read_addr: got addr=%0d sel=%0d, expected addr=%0d sel=%0d",
                   bus.rd_addr_out, bus.rd_sel_out, base + issued, oct);
        end
        checks++;
        if (issued - got >= 4) begin
          failures++;
          $display("FAIL credit: read issued with %0d in flight, expected fewer than 4", issued - got);
        end
        if (cyc <= 20) stall_reads++;
        issued++;
      end
      obs.pix = bus.pixel_out; obs.x = bus.x_out; obs.y = bus.y_out; obs.last = bus.last_out;
      if (held) begin
        checks++;
        if (bus.valid_out !== 1'b1 || obs !== hold_v) begin
          failures++;
          $display("FAIL stall_hold: got valid=%0b data=%h, expected valid=1 data=%h",
                   bus.valid_out, obs, hold_v);
        end
      end
      if (mode == 0 && first_lat >= 0) begin
        checks++;
        if (bus.valid_out !== 1'b1) begin
          failures++;
          $display("FAIL no_gap: got valid=%0b after pixel %0d, expected 1", bus.valid_out, got);
        end
      end
      held = 1'b0;
      if (bus.valid_out === 1'b1) begin
        if (first_lat < 0) first_lat = cyc;
        if (bus.ready_in) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL pixel: got extra pixel %h, expected none", obs);
          end else begin
            exp_v = sb.pop_front();
            if (obs !== exp_v) begin
              failures++;
              $display("FAIL pixel: got pix=%0d x=%0d y=%0d last=%0b, expected pix=%0d x=%0d y=%0d last=%0b",
                       obs.pix, obs.x, obs.y, obs.last, exp_v.pix, exp_v.x, exp_v.y, exp_v.last);
            end
          end
          got++;
        end else begin
          held = 1'b1;
          hold_v = obs;
        end
      end
      if (abort_after > 0 && got == abort_after) break;
    end
    if (abort_after == 0) begin
      checks++;
      if (got != npix) begin
        failures++;
        $display("FAIL pixel_count: got %0d pixels, expected %0d", got, npix);
      end
      checks++;
      if (first_lat < 2 || first_lat - 1 > 4) begin
        failures++;
        $display("FAIL latency: got %0d cycles, expected 1..4", first_lat - 1);
      end
      if (mode == 2) begin
        checks++;
        if (stall_reads != 4) begin
          failures++;
          $display("FAIL stall_reads: got %0d reads while stalled, expected 4", stall_reads);
        end
      end
      if (mid_start) begin
        checks++;
        if (err_seen) begin
          failures++;
          $display("FAIL busy_start: got error pulse=1, expected 0");
        end
      end
      @(negedge clk);
      checks++;
      if (bus.done_out !== 1'b1 || bus.busy_out !== 1'b0) begin
        failures++;
        $display("FAIL done: got done=%0b busy=%0b, expected done=1 busy=0", bus.done_out, bus.busy_out);
      end
      bus.ready_in = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.done_out !== 1'b0 || bus.valid_out !== 1'b0) begin
        failures++;
        $display("FAIL done_width: got done=%0b valid=%0b, expected 0 0", bus.done_out, bus.valid_out);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_in = 1'b0; bus.octave_in = 2'd0; bus.scale_in = 3'd0; bus.ready_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.valid_out, bus.busy_out, bus.rd_en_out, bus.done_out, bus.error_out, bus.last_out} !== 6'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, expected 000000",
               {bus.valid_out, bus.busy_out, bus.rd_en_out, bus.done_out, bus.error_out, bus.last_out});
    end
    checks++;
    if ({bus.pixel_out, bus.x_out, bus.y_out, bus.rd_addr_out} !== '0) begin
      failures++;
      $display("FAIL reset_data: got pix=%0d x=%0d y=%0d addr=%0d, expected 0",
               bus.pixel_out, bus.x_out, bus.y_out, bus.rd_addr_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_octave0_stream();
    run_image(0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_octave3();
    run_image(3, 4, 0, 0, 1'b0);
  endtask

  task automatic test_random_ready();
    run_image(1, 2, 1, 0, 1'b1);
  endtask

  task automatic test_bad_start();
    for (int s = 5; s <= 7; s += 2) begin
      @(negedge clk);
      bus.start_in = 1'b1; bus.octave_in = 2'd3; bus.scale_in = 3'(s);
      @(negedge clk);
      bus.start_in = 1'b0;
      checks++;
      if (bus.error_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.rd_en_out !== 1'b0) begin
        failures++;
        $display("FAIL bad_start: got error=%0b busy=%0b rd_en=%0b, expected 1 0 0",
                 bus.error_out, bus.busy_out, bus.rd_en_out);
      end
      @(negedge clk);
      checks++;
      if (bus.error_out !== 1'b0 || bus.busy_out !== 1'b0 || bus.rd_en_out !== 1'b0) begin
        failures++;
        $display("FAIL bad_start_after: got error=%0b busy=%0b rd_en=%0b, expected 0 0 0",
                 bus.error_out, bus.busy_out, bus.rd_en_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_image(0, 0, 0, 100, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.valid_out, bus.busy_out, bus.rd_en_out, bus.done_out, bus.last_out} !== 5'd0 ||
        {bus.pixel_out, bus.x_out, bus.y_out} !== '0) begin
      failures++;
      $display("FAIL async_reset: got valid=%0b busy=%0b rd_en=%0b done=%0b pix=%0d, expected all 0",
               bus.valid_out, bus.busy_out, bus.rd_en_out, bus.done_out, bus.pixel_out);
    end
    bus.ready_in = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.done_out !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_done: got done=%0b, expected 0", bus.done_out);
      end
    end
    rst = 1'b0;
    run_image(0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_stall_start();
    run_image(2, 1, 2, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_octave0_stream();
    test_octave3();
    test_random_ready();
    test_bad_start();
    test_reset_mid();
    test_stall_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pyramid_reader.md
Name: pyramid_reader

Overview:
- Read-side engine for the Gaussian pyramid store. On a start pulse it fetches one stored image (selected octave and blur scale) from the per-octave pyramid BRAMs in raster order.
- Each BRAM has a fixed 2-cycle read latency. The block streams pixels, with coordinates, over a valid/ready interface to downstream consumers (DoG, keypoint detection, UART dump).
- It is the consumer of the address/data layout the pyramid builder writes.

Parameters:
- WIDTH, 64, octave-0 image width in pixels (power of 2).
- HEIGHT, 64, octave-0 image height in pixels (power of 2).
- BIT_DEPTH, 8, pixel width in bits.
- OCTAVES, 4, number of octaves; octave o is (WIDTH>>o) x (HEIGHT>>o).
- SCALES, 5, blurred images per octave, stored contiguously; image s starts at s*(WIDTH>>o)*(HEIGHT>>o).
- ADDR_WIDTH, $clog2(WIDTH*HEIGHT*SCALES), BRAM address width.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- start_in  input  1  one-cycle request to read an image
- octave_in  input  2  octave select, sampled on start_in
- scale_in  input  3  scale select, sampled on start_in
- rd_en_out  output  1  BRAM read enable
- rd_sel_out  output  2  which octave BRAM the read targets
- rd_addr_out  output  ADDR_WIDTH  BRAM read address
- rd_data_in  input  BIT_DEPTH  BRAM data, valid 2 cycles after rd_en_out
- pixel_out  output  BIT_DEPTH  streamed pixel
- x_out  output  8  column of pixel_out
- y_out  output  8  row of pixel_out
- valid_out  output  1  pixel_out/x_out/y_out/last_out valid
- ready_in  input  1  downstream accepts when valid_out && ready_in
- last_out  output  1  marks the final pixel of the image
- busy_out  output  1  high from the accepted start until the last pixel is consumed
- done_out  output  1  one-cycle pulse after the last handshake
- error_out  output  1  one-cycle pulse on a rejected start

Behaviour:
- Reset is asynchronous. All outputs go to 0, the state goes to IDLE, counters clear and the FIFO empties. Reset mid-image abandons the transfer; no done_out pulse is produced.
- States:
  - IDLE: waits for start_in. An accepted start latches the octave and scale, zeroes the read counters and enters READ. busy_out is 1 from the next cycle.
  - READ: issues reads in raster order, x fastest.
  - DRAIN: all reads are issued; waits for the outstanding reads and FIFO contents to be consumed.
  - After the last handshake the block returns to IDLE with done_out=1 for exactly one cycle and busy_out=0 in that same cycle.
- Start validation: a start with octave_in>=OCTAVES or scale_in>=SCALES pulses error_out next cycle and stays in IDLE. start_in while busy is ignored, with no error.
- Read address: rd_addr_out = scale*W_o*H_o + ry*W_o + rx, where W_o=WIDTH>>octave and H_o=HEIGHT>>octave. It is computed with shifts only (no multipliers) and zero-extended to ADDR_WIDTH. rd_sel_out = latched octave.
- Flow control:
  - Output FIFO depth is 4, registered.
  - A read issues in a cycle only if (outstanding reads + FIFO occupancy) < 4. This credit rule guarantees returning data never overflows the FIFO.
  - Outstanding reads count +1 on issue and −1 on return (2-cycle delayed rd_en); simultaneous issue and return nets 0.
- Data path:
  - Returned data is pushed into the FIFO together with its x/y and a last tag; the tag travels with the pixel through the delay pipe.
  - valid_out = FIFO non-empty. FIFO push and pop in the same cycle is legal with occupancy unchanged; a pop from an empty FIFO cannot occur.
- Throughput and latency:
  - With ready_in held high the block sustains 1 pixel/cycle after an initial latency. The first valid_out appears 3 cycles after the start is accepted: issue at cycle 1, data at cycle 3, FIFO output at cycle 3 via bypass-free registered FIFO read at cycle 3–4. Latency ≤4 cycles is required; implementation documents the exact value, and tests check ≤4.
  - With ready_in low, valid_out holds and pixel_out/x_out/y_out/last_out hold stable. At most 4 pixels are in flight.
- Wrap: rx wraps from W_o−1 to 0 with ry+1. After rx=W_o−1, ry=H_o−1 is issued, the state moves to DRAIN.
- last_out=1 only on pixel (W_o−1, H_o−1). Pixel count per image is exactly W_o*H_o.
- rd_en_out is 0 in IDLE and DRAIN. rd_data_in is ignored except in the tagged return cycles.

Test Plan:
- Octave 0, scale 0, ready_in=1, BRAM model returns data = addr[7:0] → 4096 pixels in raster order; pixel k equals k[7:0]; last_out only on x=63,y=63; done_out one cycle after; no gaps after the first pixel.
- Octave 3, scale 4 → first rd_addr_out = 4*64 = 256, rd_sel_out = 3; 64 pixels with x 0..7, y 0..7; last at (7,7).
- Random ready_in (50% duty) on octave 1, scale 2 → 1024 pixels, no loss or duplication; outputs stable while stalled; outstanding+occupancy never exceeds 4 (assertion).
- start_in with octave_in=3, scale_in=5 (SCALES=5) → error_out pulse, busy_out stays 0, no rd_en_out; start_in mid-transfer → ignored, sequence unaffected.
- Assert rst_in after 100 pixels of octave 0 → outputs 0 immediately (asynchronous), no done_out; a fresh start then reads from address 0 correctly.
- ready_in=0 for 20 cycles right after start → exactly 4 reads issued, then rd_en_out held 0; on release, pixels 0..3 are delivered in order and streaming resumes.
